// File: rtl/noc_out_arb.sv
// Packet-atomic round-robin arbiter sharing one outbound AXI-stream port through a 2-entry skid buffer.
// Optional per-requester saturating packet counters are built when NOC_OUT_ARB_STATS_EN is defined.
module noc_out_arb #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk_ctrl,
  input  logic                      clk_ctrl_rst_low,
  input  logic [N_REQ-1:0]          in_TVALID,
  input  logic [N_REQ*DATA_W-1:0]   in_TDATA,
  input  logic [N_REQ*DATA_W/8-1:0] in_TKEEP,
  input  logic [N_REQ-1:0]          in_TLAST,
  output logic [N_REQ-1:0]          in_TREADY,
  output logic                      out_TVALID,
  output logic [DATA_W-1:0]         out_TDATA,
  output logic [DATA_W/8-1:0]       out_TKEEP,
  output logic                      out_TLAST,
  input  logic                      out_TREADY,
  output logic [N_REQ-1:0]          grant,
  output logic                      arb_idle
`ifdef NOC_OUT_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]       pkt_cnt,
  input  logic                      stats_clr
`endif
);

  localparam int unsigned KW = DATA_W / 8;
  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned BW = DATA_W + KW + 1;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  arb_state_t       r_state;
  logic [PW-1:0]    r_rr_ptr;
  logic [PW-1:0]    r_gidx;
  logic [N_REQ-1:0] r_grant;
  logic [BW-1:0]    r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             r_full;

  logic             w_hit;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_cand;
  logic [BW-1:0]    w_beat;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;

  // Round-robin search starting one past the previous owner.
  always_comb begin
    w_hit  = 1'b0;
    w_win  = r_rr_ptr;
    w_cand = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_cand = PW'((32'(r_rr_ptr) + k) % N_REQ);
      if (!w_hit && in_TVALID[w_cand]) begin
        w_hit = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_comb begin
    w_beat = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_beat = {in_TDATA[i*DATA_W +: DATA_W], in_TKEEP[i*KW +: KW], in_TLAST[i]};
      end
    end
  end

  // Ready depends only on registered state: the grant and the registered full flag.
  assign in_TREADY = r_grant & {N_REQ{~r_full}};
  assign w_push    = |(in_TVALID & in_TREADY);
  assign w_pop     = out_TVALID & out_TREADY;
  assign w_cnt_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
    if (!clk_ctrl_rst_low) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= PW'(N_REQ - 1);
      r_gidx   <= '0;
      r_grant  <= '0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_hit) begin
            r_grant <= N_REQ'(1) << w_win;
            r_gidx  <= w_win;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (w_push && w_beat[0]) begin
            r_rr_ptr <= r_gidx;
            r_grant  <= '0;
            r_state  <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == 2'd2);
    end
  end

  assign out_TVALID = (r_count != 2'd0);
  assign {out_TDATA, out_TKEEP, out_TLAST} = r_mem[r_rd_ptr];
  assign grant      = r_grant;
  assign arb_idle   = (r_state == ARB_IDLE) && (r_count == 2'd0);

`ifdef NOC_OUT_ARB_STATS_EN
  logic [N_REQ*16-1:0] r_pkt_cnt;

  always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
    if (!clk_ctrl_rst_low) begin
      r_pkt_cnt <= '0;
    end else if (stats_clr) begin
      r_pkt_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (in_TVALID[i] && in_TREADY[i] && in_TLAST[i] &&
            (r_pkt_cnt[i*16 +: 16] != 16'hFFFF)) begin
          r_pkt_cnt[i*16 +: 16] <= r_pkt_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_noc_out_arb.sv
// Self-checking bench for noc_out_arb: queued per-requester packets, transaction-level reference model.
module tb_noc_out_arb;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    in_TVALID = '0;
  logic [N*DW-1:0] in_TDATA  = '0;
  logic [N*KW-1:0] in_TKEEP  = '0;
  logic [N-1:0]    in_TLAST  = '0;
  logic [N-1:0]    in_TREADY;
  logic            out_TVALID;
  logic [DW-1:0]   out_TDATA;
  logic [KW-1:0]   out_TKEEP;
  logic            out_TLAST;
  logic            out_TREADY = 1'b0;
  logic [N-1:0]    grant;
  logic            arb_idle;
`ifdef NOC_OUT_ARB_STATS_EN
  logic [N*16-1:0] pkt_cnt;
  logic            stats_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  noc_out_arb #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk_ctrl         (clk),
    .clk_ctrl_rst_low (rst_n),
    .in_TVALID        (in_TVALID),
    .in_TDATA         (in_TDATA),
    .in_TKEEP         (in_TKEEP),
    .in_TLAST         (in_TLAST),
    .in_TREADY        (in_TREADY),
    .out_TVALID       (out_TVALID),
    .out_TDATA        (out_TDATA),
    .out_TKEEP        (out_TKEEP),
    .out_TLAST        (out_TLAST),
    .out_TREADY       (out_TREADY),
    .grant            (grant),
    .arb_idle         (arb_idle)
`ifdef NOC_OUT_ARB_STATS_EN
    ,
    .pkt_cnt          (pkt_cnt),
    .stats_clr        (stats_clr)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: per-requester packet sources, owner bookkeeping and a FIFO of beats in flight.
  beat_t       src_q [N][$];
  beat_t       m_q [$];
  bit          m_busy  = 1'b0;
  int unsigned m_owner = 0;
  int unsigned m_last  = N - 1;
  bit          holding [N];
  int unsigned p_valid = 100;
  int unsigned p_ready = 100;
  int unsigned n_last_in  = 0;
  int unsigned n_last_out = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int unsigned i);
    return N'(1) << i;
  endfunction

  function automatic bit all_src_empty();
    bit e = 1'b1;
    for (int unsigned i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic push_beat(input int unsigned r, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    src_q[r].push_back(b);
  endtask

  task automatic add_pkt(input int unsigned r, input int unsigned len);
    for (int unsigned j = 0; j < len; j++)
      push_beat(r, $urandom, KW'($urandom_range(15, 1)), j == len - 1);
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    eg = m_busy ? onehot(m_owner) : '0;
    er = (m_busy && m_q.size() < 2) ? eg : '0;
    check_eq("grant",      64'(grant),      64'(eg));
    check_eq("in_tready",  64'(in_TREADY),  64'(er));
    check_eq("out_tvalid", 64'(out_TVALID), 64'(m_q.size() > 0));
    check_eq("arb_idle",   64'(arb_idle),   64'(!m_busy && m_q.size() == 0));
    if (m_q.size() > 0)
      check_eq("out_beat", 64'({out_TDATA, out_TKEEP, out_TLAST}), 64'(m_q[0]));
  endtask

  task automatic drive_inputs();
    for (int unsigned i = 0; i < N; i++) begin
      bit v;
      v = (src_q[i].size() > 0) && (holding[i] || ($urandom_range(99) < p_valid));
      in_TVALID[i]         = v;
      in_TDATA[i*DW +: DW] = v ? src_q[i][0].d : DW'($urandom);
      in_TKEEP[i*KW +: KW] = v ? src_q[i][0].k : KW'($urandom);
      in_TLAST[i]          = v ? src_q[i][0].l : 1'($urandom);
    end
    out_TREADY = ($urandom_range(99) < p_ready);
  endtask

  // Predict the effect of the coming clock edge from the inputs just driven.
  task automatic step_model();
    bit    pop;
    bit    push;
    beat_t b;
    int unsigned c;
    pop  = (m_q.size() > 0) && out_TREADY;
    push = 1'b0;
    b    = '0;
    if (out_TVALID && out_TREADY && out_TLAST) n_last_out++;
    if (m_q.size() == 2) check_eq("push_when_full", 64'(in_TVALID & in_TREADY), 64'(0));
    for (int unsigned i = 0; i < N; i++) holding[i] = in_TVALID[i];
    if (m_busy) begin
      if (m_q.size() < 2 && in_TVALID[m_owner]) begin
        push = 1'b1;
        b = src_q[m_owner].pop_front();
        holding[m_owner] = 1'b0;
        if (b.l) begin
          m_busy = 1'b0;
          m_last = m_owner;
          n_last_in++;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (in_TVALID[c]) begin
          m_busy  = 1'b1;
          m_owner = c;
          break;
        end
      end
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(b);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    check_outputs();
    drive_inputs();
    step_model();
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_tvalid", 64'(out_TVALID), 64'(0));
    check_eq("rst_grant",      64'(grant),      64'(0));
    check_eq("rst_arb_idle",   64'(arb_idle),   64'(1));
    check_eq("rst_in_tready",  64'(in_TREADY),  64'(0));
    check_eq("rst_out_beat",   64'({out_TDATA, out_TKEEP, out_TLAST}), 64'(0));
    for (int unsigned i = 0; i < N; i++) begin
      src_q[i].delete();
      holding[i] = 1'b0;
    end
    m_q.delete();
    m_busy     = 1'b0;
    m_last     = N - 1;
    n_last_in  = 0;
    n_last_out = 0;
    in_TVALID  = '0;
    in_TLAST   = '0;
    out_TREADY = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!(all_src_empty() && !m_busy && m_q.size() == 0) && n < budget) begin
      cycle();
      n++;
    end
    check_eq({tag, "_drained"}, 64'(all_src_empty() && !m_busy && m_q.size() == 0), 64'(1));
    cycle();
    cycle();
    check_eq({tag, "_tlast_cnt"}, 64'(n_last_out), 64'(n_last_in));
  endtask

  initial begin
    for (int unsigned i = 0; i < N; i++) holding[i] = 1'b0;
    apply_reset();

    // Single 2-beat packet from req0.
    p_valid = 100; p_ready = 100;
    push_beat(0, 32'h0070_1234, 4'hF, 1'b0);
    push_beat(0, 32'hDEADBEEF,  4'hF, 1'b1);
    drain("single", 50);

    // req0 and req1 together after reset, then a third pair.
    apply_reset();
    add_pkt(0, 2); add_pkt(1, 2);
    drain("pair", 50);
    add_pkt(0, 1); add_pkt(1, 1);
    drain("pair2", 50);

    // req0 arrives in the middle of a req1 packet.
    add_pkt(1, 4);
    cycle(); cycle(); cycle();
    add_pkt(0, 2);
    drain("nointerleave", 50);

    // Downstream stalled during a 4-beat packet.
    p_ready = 0;
    add_pkt(0, 4);
    for (int k = 0; k < 8; k++) cycle();
    p_ready = 100;
    drain("backpressure", 50);

    // Reset part way through a 3-beat packet.
    p_ready = 0;
    add_pkt(0, 3);
    cycle(); cycle(); cycle();
    apply_reset();
    p_ready = 100;
    add_pkt(1, 3);
    drain("after_reset", 50);

    // Random contention and backpressure.
    p_valid = 70; p_ready = 60;
    for (int k = 0; k < 60; k++) add_pkt($urandom_range(N - 1), $urandom_range(5, 1));
    drain("random_a", 5000);
    p_valid = 40; p_ready = 85;
    for (int k = 0; k < 60; k++) add_pkt($urandom_range(N - 1), $urandom_range(4, 1));
    drain("random_b", 5000);

`ifdef NOC_OUT_ARB_STATS_EN
    apply_reset();
    p_valid = 100; p_ready = 100;
    for (int k = 0; k < 3; k++) add_pkt(0, 2);
    add_pkt(1, 1);
    drain("stats", 200);
    check_eq("pkt_cnt", 64'(pkt_cnt), 64'({16'd0, 16'd1, 16'd3}));
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    check_eq("pkt_cnt_clr", 64'(pkt_cnt), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_out_arb.md
Name: noc_out_arb

Overview:
- Packet-atomic round-robin arbiter. It shares one outbound NoC AXI-stream port between N_REQ tile-side requesters, e.g. the memory spy and the message-queue engines.
- Sits in clk_ctrl domain, in front of the tile's noc_buffer_out CDC FIFO.
- Once a requester is granted, every beat through TLAST is forwarded before the next grant. Header/data pairs therefore never interleave.
- Output passes through a 2-entry skid buffer, so the TREADY driven back to requesters is registered.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 32, stream data width; TKEEP width is DATA_W/8.

Ports:
- clk_ctrl  input  1  single clock.
- clk_ctrl_rst_low  input  1  asynchronous active-low reset.
- in_TVALID  input  N_REQ  per-requester valid.
- in_TDATA  input  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- in_TKEEP  input  N_REQ*DATA_W/8  per-requester keep, packed the same way.
- in_TLAST  input  N_REQ  per-requester last.
- in_TREADY  output  N_REQ  per-requester ready; only the granted bit may be 1.
- out_TVALID  output  1  to noc_buffer_out.
- out_TDATA  output  DATA_W
- out_TKEEP  output  DATA_W/8
- out_TLAST  output  1
- out_TREADY  input  1  from noc_buffer_out.
- grant  output  N_REQ  one-hot current owner; all zero when idle.
- arb_idle  output  1  high when in ARB_IDLE and the skid buffer is empty.

Behaviour:
- Reset values:
  - in_TREADY=0, out_TVALID=0, out_TDATA=0, out_TKEEP=0, out_TLAST=0.
  - grant=0, arb_idle=1.
  - state=ARB_IDLE, rr_ptr=N_REQ-1, so requester 0 wins first.
  - Skid buffer is empty.
- Reset is asynchronous. Asserting it mid-packet discards the partial packet and the buffer contents; no TLAST is synthesised.
- State ARB_IDLE:
  - Search starts at rr_ptr+1, modulo N_REQ, and takes the first i with in_TVALID[i]=1.
  - On a hit: register grant=onehot(i), go to ARB_BUSY.
  - in_TREADY stays 0 this cycle.
  - Result: 1 cycle of arbitration latency, and at least 1 bubble cycle between packets.
- State ARB_BUSY:
  - in_TREADY[g] = skid buffer not full, using the registered full flag.
  - A beat is accepted when in_TVALID[g] and in_TREADY[g] are both 1. It is written into the skid buffer as {TDATA,TKEEP,TLAST}.
  - Accepted beat with TLAST=1: rr_ptr<=g, grant<=0, state<=ARB_IDLE, in the same cycle.
  - Beats from non-granted requesters are ignored. Their TVALID may toggle without effect.
- Skid buffer:
  - 2-entry FIFO; head drives out_*.
  - out_TVALID = not empty. Pop when out_TVALID and out_TREADY are both 1.
  - Simultaneous push and pop keeps the count unchanged. Full gives 100% throughput.
  - Push when full never happens, because TREADY is gated. Bench asserts this.
- Back-to-back packets from the same requester: if it is the only valid requester, it wins again after the 1-cycle idle.
- Requester with TVALID=1 and TLAST never arriving holds the port indefinitely. There is no timeout.
- Boundary conditions:
  - All requesters idle: grant stays 0 and rr_ptr is unchanged.
  - rr_ptr=N_REQ-1 wraps to search from 0.
  - out_TREADY held 0: buffer fills after 2 beats, then in_TREADY drops. No data is lost or duplicated.
- Bench assertion: out_TLAST beats must equal accepted input TLAST beats.

Optional Feature:
- Macro NOC_OUT_ARB_STATS_EN.
- When defined:
  - Adds output pkt_cnt, width N_REQ*16: one saturating 16-bit counter per requester.
  - A counter increments when an input TLAST beat from that requester is accepted. It saturates at 16'hFFFF.
  - Adds input stats_clr, width 1: a synchronous clear of all counters with priority over increment.
  - Counters reset to 0.
- When undefined: neither port exists and no counter logic is built. Datapath behaviour is identical.

Test Plan:
- Req0 only, 2-beat packet {header 32'h0070_1234, data 32'hDEADBEEF}, out_TREADY=1.
  - Expect grant=01 one cycle after TVALID, then both beats on out_* in order with TLAST on beat 2.
  - Expect arb_idle=1 again after the drain.
- Req0 and req1 both raise TVALID in the same cycle after reset.
  - Expect req0's packet complete first, then req1's. rr_ptr ends at 1.
  - A third packet offered on both then goes to req0.
- Req1 sends a 4-beat packet; req0 raises TVALID at beat 2.
  - Expect no req0 beat on out_* before req1's TLAST; req0 granted afterwards.
- out_TREADY=0 during a 4-beat packet.
  - Expect 2 beats buffered, then in_TREADY[g]=0.
  - On release, all 4 beats in order with no duplicates.
- Reset asserted mid-way through a 3-beat packet.
  - Expect out_TVALID=0, grant=0, arb_idle=1 immediately.
  - Next packet from req1 arrives intact with req0 idle.
- With NOC_OUT_ARB_STATS_EN: 3 packets from req0 and 1 from req1.
  - Expect pkt_cnt = {16'd1,16'd3}; stats_clr gives all zeros.
  - Forcing req0's counter to 16'hFFFF, a further packet keeps it at 16'hFFFF.
